dp_ram_be: RTL and testbench
============================

// Module: dp_ram_be
// PURPOSE
// - True dual-port synchronous RAM with per-byte write enables and deterministic cross-port collision handling.
// - Built-in clear-on-reset sweep.
// - Shared storage for cache tag/data arrays and CPU/VGA shared buffers; drop-in successor for plain dual-port RAMs.
// PARAMETERS
// - words      256  number of entries; addr_bits = $clog2(words)
// - width      16   data bits; must be a multiple of 8
// - read_mode  0    same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
// - clear_val  0    value written to every entry by the reset sweep; width bits
// - nbytes     --   localparam, width/8
// PORTS
// - clk         in   1          clock; all logic on posedge
// - reset       in   1          synchronous, active-high
// - init_busy   out  1          high while clear sweep in progress; ports ignored
// - addr_a      in   addr_bits  port A address
// - wr_en_a     in   1          port A write strobe
// - be_a        in   nbytes     port A byte enables; bit i selects wdata_a[8i+7:8i]
// - wdata_a     in   width      port A write data
// - q_a         out  width      port A read data
// - addr_b, wr_en_b, be_b, wdata_b, q_b: as port A, for port B
// BEHAVIOUR
// - Reset values: q_a = q_b = 0, init_busy = 1; sweep address counter = 0.
// - Clear FSM states and transitions:
//   - CLEAR: entered while reset is high. Writes clear_val to entry cnt each cycle after reset falls; cnt increments.
//   - At cnt == words-1, moves to RUN and init_busy falls on the next edge: words cycles after reset deassert.
//   - RUN: normal operation.
//   - reset asserted in any state, including mid-sweep: back to CLEAR with cnt = 0.
// - During CLEAR: wr_en_a/wr_en_b ignored; q_a/q_b held at 0.
// - Read latency 1: q_x shows entry addr_x as sampled on the previous edge. q_x holds its value when nothing changes; every cycle is a read.
// - Write: on posedge with wr_en_x, byte i of ram[addr_x] is updated only if be_x[i]. wr_en_x with be_x == 0 is a no-op.
// - Same-port read-during-write follows read_mode:
//   - read_mode 0: q_x = pre-write entry.
//   - read_mode 1: q_x = pre-write entry with the enabled bytes replaced by wdata_x.
// - Cross-port read-during-write (addr_a == addr_b, other port writing): the reader sees new data for bytes the other port enabled and old data for the rest.
//   - Implemented with a registered bypass value and a per-byte bypass mask, not array read-through.
// - Dual write collision, same address:
//   - Overlapping enabled bytes: port B wins.
//   - Non-overlapping bytes: both apply.
//   - Both ports' q (write-first, or bypass) reflect the final merged entry.
// - Address >= words (non-power-of-2 depth): write dropped, read returns 0.
// CONFIGURATION
// - DP_RAM_BE_OUTPUT_REG_EN defined:
//   - Extra output register on q_a/q_b; read latency 2.
//   - Bypass and collision results are delayed by the same stage.
//   - Register reset value is 0 and it holds 0 during CLEAR.
// - Undefined: latency 1 as above.
// - init_busy timing is identical in both builds.
// TESTING
// - Sweep: words=16, clear_val=16'hA5A5; release reset, hold ports idle.
//   -> init_busy high 16 cycles then low; read of any address returns A5A5.
// - Byte writes: addr 3 = 16'h1234, then B writes be_b=2'b10, wdata 16'hFF00 to addr 3.
//   -> A reads 16'hFF34 next cycle (or cycle+2 with OUTPUT_REG_EN).
// - Cross bypass: A writes 16'hBEEF to addr 5 while B reads addr 5 the same cycle.
//   -> q_b = 16'hBEEF after 1 cycle; repeat with be_a=2'b01 over old 16'h1111 -> q_b = 16'h11EF.
// - Dual write collision: A writes 16'hAAAA, B writes 16'h5555 to addr 7, both be=2'b11.
//   -> entry 7 = 16'h5555 and q_a = q_b = 16'h5555.
// - Same-port mode: entry 2 = 16'h0001; A writes 16'h0002 to addr 2.
//   -> read_mode 0: q_a = 0001; read_mode 1: q_a = 0002.
// - Reset mid-sweep: assert reset at cnt=9 for 1 cycle, with writes presented during CLEAR.
//   -> sweep restarts at 0, init_busy low exactly words cycles after the second release, and the CLEAR-time writes are absent.

Source files
------------

// File: rtl/dp_ram_be.sv
// dp_ram_be: true dual-port RAM with per-byte write enables, registered cross-port bypass and a clear-on-reset sweep.
// Build option DP_RAM_BE_OUTPUT_REG_EN adds an output register on q_a/q_b (read latency 2).
module dp_ram_be #(
    parameter int unsigned      words     = 256,
    parameter int unsigned      width     = 16,
    parameter int unsigned      read_mode = 0,
    parameter logic [width-1:0] clear_val = '0,
    localparam int unsigned     addr_bits = (words > 1) ? $clog2(words) : 1,
    localparam int unsigned     nbytes    = width / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 init_busy,
    input  logic [addr_bits-1:0] addr_a,
    input  logic                 wr_en_a,
    input  logic [nbytes-1:0]    be_a,
    input  logic [width-1:0]     wdata_a,
    output logic [width-1:0]     q_a,
    input  logic [addr_bits-1:0] addr_b,
    input  logic                 wr_en_b,
    input  logic [nbytes-1:0]    be_b,
    input  logic [width-1:0]     wdata_b,
    output logic [width-1:0]     q_b
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [addr_bits-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    logic [width-1:0]     ram [words];
    logic [width-1:0]     ram_rd_a_q, ram_rd_b_q;

    logic                 run, sweep_we;
    logic                 valid_a, valid_b, we_a, we_b, same_addr, collide;
    logic                 rd_valid_a_d, rd_valid_a_q, rd_valid_b_d, rd_valid_b_q;
    logic [width-1:0]     byp_a_d, byp_a_q, byp_b_d, byp_b_q;
    logic [nbytes-1:0]    mask_a_d, mask_a_q, mask_b_d, mask_b_q;
    logic [width-1:0]     q_a_c, q_b_c;

    // Clear sweep sequencing: one entry per cycle, then RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + addr_bits'(1);
                if (32'(cnt_q) == words - 1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Port qualification; out-of-range addresses never write and read as zero.
    always_comb begin
        run       = (state_q == RUN) && !reset;
        sweep_we  = (state_q == CLEAR) && !reset;
        valid_a   = 32'(addr_a) < words;
        valid_b   = 32'(addr_b) < words;
        we_a      = run && wr_en_a && valid_a;
        we_b      = run && wr_en_b && valid_b;
        same_addr = addr_a == addr_b;
        collide   = we_a && we_b && same_addr;
        rd_valid_a_d = run && valid_a;
        rd_valid_b_d = run && valid_b;
    end

    // Bypass bytes each reader must see instead of the (read-first) array output.
    // Port B wins overlapping bytes; on a dual-write collision both readers see the merged entry.
    always_comb begin
        byp_a_d  = '0;
        byp_b_d  = '0;
        mask_a_d = '0;
        mask_b_d = '0;
        for (int i = 0; i < int'(nbytes); i++) begin
            if (we_b && same_addr && be_b[i]) begin
                byp_a_d[8*i +: 8] = wdata_b[8*i +: 8];
                mask_a_d[i]       = 1'b1;
            end else if (we_a && be_a[i] && (read_mode != 0 || collide)) begin
                byp_a_d[8*i +: 8] = wdata_a[8*i +: 8];
                mask_a_d[i]       = 1'b1;
            end
            if (we_b && be_b[i] && (read_mode != 0 || collide)) begin
                byp_b_d[8*i +: 8] = wdata_b[8*i +: 8];
                mask_b_d[i]       = 1'b1;
            end else if (we_a && same_addr && be_a[i]) begin
                byp_b_d[8*i +: 8] = wdata_a[8*i +: 8];
                mask_b_d[i]       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            byp_a_q      <= '0;
            byp_b_q      <= '0;
            mask_a_q     <= '0;
            mask_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            byp_a_q      <= byp_a_d;
            byp_b_q      <= byp_b_d;
            mask_a_q     <= mask_a_d;
            mask_b_q     <= mask_b_d;
        end
    end

    // Storage array: no reset, read-first, port B write applied last so it wins overlapping bytes.
    always_ff @(posedge clk) begin
        ram_rd_a_q <= ram[addr_a];
        ram_rd_b_q <= ram[addr_b];
        if (sweep_we) begin
            ram[cnt_q] <= clear_val;
        end
        for (int i = 0; i < int'(nbytes); i++) begin
            if (we_a && be_a[i]) begin
                ram[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
            end
        end
        for (int i = 0; i < int'(nbytes); i++) begin
            if (we_b && be_b[i]) begin
                ram[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
            end
        end
    end

    always_comb begin
        q_a_c = '0;
        q_b_c = '0;
        for (int i = 0; i < int'(nbytes); i++) begin
            q_a_c[8*i +: 8] = mask_a_q[i] ? byp_a_q[8*i +: 8]
                                          : (rd_valid_a_q ? ram_rd_a_q[8*i +: 8] : 8'h00);
            q_b_c[8*i +: 8] = mask_b_q[i] ? byp_b_q[8*i +: 8]
                                          : (rd_valid_b_q ? ram_rd_b_q[8*i +: 8] : 8'h00);
        end
    end

`ifdef DP_RAM_BE_OUTPUT_REG_EN
    logic [width-1:0] q_a_d, q_a_q, q_b_d, q_b_q;

    always_comb begin
        q_a_d = (state_q == RUN) ? q_a_c : '0;
        q_b_d = (state_q == RUN) ? q_b_c : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
        end
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;
`else
    assign q_a = q_a_c;
    assign q_b = q_b_c;
`endif

    assign init_busy = busy_q;

endmodule

// File: tb/tb_dp_ram_be.sv
// Testbench for dp_ram_be: two instances (16 words read-first, 12 words write-first) on shared stimulus,
// checked every cycle against an entry-level reference model plus directed constant checks.
module tb_dp_ram_be;

`ifdef DP_RAM_BE_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [15:0] CV = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  addr_a, addr_b;
    logic        wr_en_a, wr_en_b;
    logic [1:0]  be_a, be_b;
    logic [15:0] wdata_a, wdata_b;
    logic [15:0] q_a0, q_b0, q_a1, q_b1;
    logic        busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dp_ram_be #(.words(16), .width(16), .read_mode(0), .clear_val(CV)) u_dut0 (
        .clk(clk), .reset(reset), .init_busy(busy0),
        .addr_a(addr_a), .wr_en_a(wr_en_a), .be_a(be_a), .wdata_a(wdata_a), .q_a(q_a0),
        .addr_b(addr_b), .wr_en_b(wr_en_b), .be_b(be_b), .wdata_b(wdata_b), .q_b(q_b0)
    );

    dp_ram_be #(.words(12), .width(16), .read_mode(1), .clear_val(CV)) u_dut1 (
        .clk(clk), .reset(reset), .init_busy(busy1),
        .addr_a(addr_a), .wr_en_a(wr_en_a), .be_a(be_a), .wdata_a(wdata_a), .q_a(q_a1),
        .addr_b(addr_b), .wr_en_b(wr_en_b), .be_b(be_b), .wdata_b(wdata_b), .q_b(q_b1)
    );

    // Reference model state: entry contents, sweep progress, and expected read pipeline.
    logic [15:0] mem [2][16];
    bit          mbusy [2];
    int          mcnt [2];
    logic [15:0] e1a [2], e1b [2], e2a [2], e2b [2];

    function automatic int nw(input int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic bit rmode(input int d);
        return d == 1;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] w, input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = w[7:0];
        if (be[1]) r[15:8] = w[15:8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Entry-level model of one clock edge: a reader sees the other port's write to its address,
    // its own write only in write-first mode or on a dual-write collision; B's bytes land last.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [15:0] ra, rb;
            bit va, vb, wa, wb, same, coll;
            ra = 16'h0;
            rb = 16'h0;
            if (reset) begin
                mbusy[d] = 1'b1;
                mcnt[d]  = 0;
            end else if (mbusy[d]) begin
                mem[d][mcnt[d]] = CV;
                mcnt[d]++;
                if (mcnt[d] == nw(d)) mbusy[d] = 1'b0;
            end else begin
                va   = int'(addr_a) < nw(d);
                vb   = int'(addr_b) < nw(d);
                wa   = wr_en_a && va;
                wb   = wr_en_b && vb;
                same = addr_a == addr_b;
                coll = wa && wb && same;
                ra   = va ? mem[d][addr_a] : 16'h0;
                rb   = vb ? mem[d][addr_b] : 16'h0;
                if (wa && (rmode(d) || coll)) ra = merge(ra, wdata_a, be_a);
                if (wb && same)               ra = merge(ra, wdata_b, be_b);
                if (wa && same)               rb = merge(rb, wdata_a, be_a);
                if (wb && (rmode(d) || coll)) rb = merge(rb, wdata_b, be_b);
                if (wa) mem[d][addr_a] = merge(mem[d][addr_a], wdata_a, be_a);
                if (wb) mem[d][addr_b] = merge(mem[d][addr_b], wdata_b, be_b);
            end
            if (reset) begin
                e2a[d] = 16'h0;
                e2b[d] = 16'h0;
            end else begin
                e2a[d] = e1a[d];
                e2b[d] = e1b[d];
            end
            e1a[d] = ra;
            e1b[d] = rb;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("q_a0",  32'(q_a0),  32'((LAT == 1) ? e1a[0] : e2a[0]));
        check("q_b0",  32'(q_b0),  32'((LAT == 1) ? e1b[0] : e2b[0]));
        check("q_a1",  32'(q_a1),  32'((LAT == 1) ? e1a[1] : e2a[1]));
        check("q_b1",  32'(q_b1),  32'((LAT == 1) ? e1b[1] : e2b[1]));
        check("busy0", 32'(busy0), 32'(mbusy[0]));
        check("busy1", 32'(busy1), 32'(mbusy[1]));
    endtask

    task automatic idle();
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    // Let the last issued read reach the outputs, holding addresses with writes off.
    task automatic settle();
        idle();
        repeat (LAT - 1) step();
    endtask

    task automatic rand_ports();
        addr_a  = 4'($urandom_range(0, 15));
        addr_b  = ($urandom_range(0, 9) < 4) ? addr_a : 4'($urandom_range(0, 15));
        wr_en_a = 1'($urandom_range(0, 1));
        wr_en_b = 1'($urandom_range(0, 1));
        be_a    = 2'($urandom);
        be_b    = 2'($urandom);
        wdata_a = 16'($urandom);
        wdata_b = 16'($urandom);
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [1:0] be, input logic [15:0] w);
        addr_a = a; wr_en_a = 1'b1; be_a = be; wdata_a = w;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [1:0] be, input logic [15:0] w);
        addr_b = a; wr_en_b = 1'b1; be_b = be; wdata_b = w;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0, n1;
        bit  f0, f1;
        reset = 1'b1;
        addr_a = '0; addr_b = '0; be_a = '0; be_b = '0; wdata_a = '0; wdata_b = '0;
        idle();
        repeat (2) step();

        // Partial sweep with writes presented, then reset again at cnt=9.
        reset = 1'b0;
        repeat (9) begin rand_ports(); step(); end
        reset = 1'b1;
        rand_ports();
        step();
        reset = 1'b0;
        n0 = 0; n1 = 0; f0 = 1'b0; f1 = 1'b0;
        for (int k = 0; k < 64 && !(f0 && f1); k++) begin
            if (k < 10) rand_ports(); else idle();
            step();
            if (!f0 && !busy0) begin n0 = k + 1; f0 = 1'b1; end
            if (!f1 && !busy1) begin n1 = k + 1; f1 = 1'b1; end
        end
        check("busy_len0", 32'(n0), 32'd16);
        check("busy_len1", 32'(n1), 32'd12);

        // Every entry holds the clear value; out-of-range read is zero.
        idle();
        for (int a = 0; a < 16; a++) begin
            addr_a = 4'(a); addr_b = 4'(15 - a);
            step();
        end
        addr_a = 4'd9; addr_b = 4'd13;
        step(); settle();
        check("sweep_a0", 32'(q_a0), 32'h0000A5A5);
        check("sweep_a1", 32'(q_a1), 32'h0000A5A5);
        check("sweep_b0", 32'(q_b0), 32'h0000A5A5);
        check("oob_b1",   32'(q_b1), 32'h0);

        // Byte-enabled overwrite seen by the other port.
        idle(); wr_a(4'd3, 2'b11, 16'h1234); addr_b = 4'd0;
        step();
        idle(); addr_a = 4'd3; wr_b(4'd3, 2'b10, 16'hFF00);
        step(); settle();
        check("bytewr_a0", 32'(q_a0), 32'h0000FF34);
        check("bytewr_a1", 32'(q_a1), 32'h0000FF34);

        // Cross-port bypass, full and partial.
        idle(); wr_a(4'd5, 2'b11, 16'hBEEF); addr_b = 4'd5;
        step(); settle();
        check("bypass_b0", 32'(q_b0), 32'h0000BEEF);
        check("bypass_b1", 32'(q_b1), 32'h0000BEEF);
        idle(); wr_a(4'd5, 2'b11, 16'h1111); addr_b = 4'd0;
        step();
        idle(); wr_a(4'd5, 2'b01, 16'h22EF); addr_b = 4'd5;
        step(); settle();
        check("bypass_part_b0", 32'(q_b0), 32'h000011EF);
        check("bypass_part_b1", 32'(q_b1), 32'h000011EF);

        // Dual-write collision: B wins all bytes.
        idle(); wr_a(4'd7, 2'b11, 16'hAAAA); wr_b(4'd7, 2'b11, 16'h5555);
        step(); settle();
        check("coll_a0", 32'(q_a0), 32'h00005555);
        check("coll_b0", 32'(q_b0), 32'h00005555);
        check("coll_a1", 32'(q_a1), 32'h00005555);
        idle(); addr_a = 4'd7; addr_b = 4'd7;
        step(); settle();
        check("coll_entry0", 32'(q_a0), 32'h00005555);
        // Non-overlapping collision: both apply.
        idle(); wr_a(4'd7, 2'b01, 16'h0012); wr_b(4'd7, 2'b10, 16'h3400);
        step(); settle();
        check("coll_merge_a0", 32'(q_a0), 32'h00003412);
        check("coll_merge_b1", 32'(q_b1), 32'h00003412);

        // Same-port read-during-write in both modes.
        idle(); wr_a(4'd2, 2'b11, 16'h0001); addr_b = 4'd0;
        step();
        wr_a(4'd2, 2'b11, 16'h0002);
        step(); settle();
        check("rmode0_a", 32'(q_a0), 32'h00000001);
        check("rmode1_a", 32'(q_a1), 32'h00000002);

        // Randomized traffic with a mid-run reset and re-sweep.
        for (int n = 0; n < 400; n++) begin
            reset = (n == 200);
            rand_ports();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
